// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding register per functional unit, round-robin
// selection of a single held result per cycle into a registered ROB writeback port.
module wb_arbiter #(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned ROB_IDX_W   = 6,
  parameter int unsigned SB_IDX_W    = 4,
  parameter int unsigned XCPT_CODE_W = 4,
  parameter logic [XCPT_CODE_W-1:0] XCPT_ILLEGAL_INSTR = XCPT_CODE_W'(2)
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  input  logic                                  flush_i,
  input  logic [NUM_REQ-1:0]                    req_valid_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  input  logic [NUM_REQ-1:0][ROB_IDX_W-1:0]     req_rob_idx_i,
  input  logic [NUM_REQ-1:0][31:0]              req_result_i,
  input  logic [NUM_REQ-1:0][31:0]              req_new_pc_i,
  input  logic [NUM_REQ-1:0]                    req_branch_taken_i,
  input  logic [NUM_REQ-1:0]                    req_xcpt_i,
  input  logic [NUM_REQ-1:0][XCPT_CODE_W-1:0]   req_xcpt_code_i,
  input  logic [NUM_REQ-1:0][SB_IDX_W-1:0]      req_sb_idx_i,
  output logic                                  wb_valid_o,
  output logic [ROB_IDX_W-1:0]                  wb_rob_idx_o,
  output logic [31:0]                           wb_result_o,
  output logic [31:0]                           wb_new_pc_o,
  output logic                                  wb_branch_taken_o,
  output logic [SB_IDX_W-1:0]                   wb_sb_idx_o,
  output logic                                  wb_xcpt_o,
  output logic [XCPT_CODE_W-1:0]                wb_xcpt_code_o,
  output logic [NUM_REQ-1:0]                    grant_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned IDX_W = PTR_W + 1;

  typedef struct packed {
    logic [ROB_IDX_W-1:0]   rob_idx;
    logic [31:0]            result;
    logic [31:0]            new_pc;
    logic                   branch_taken;
    logic                   xcpt;
    logic [XCPT_CODE_W-1:0] xcpt_code;
    logic [SB_IDX_W-1:0]    sb_idx;
  } payload_t;

  localparam payload_t WB_IDLE = '{rob_idx: '0, result: '0, new_pc: '0,
                                   branch_taken: 1'b0, xcpt: 1'b0,
                                   xcpt_code: XCPT_ILLEGAL_INSTR, sb_idx: '0};

  logic     [NUM_REQ-1:0] hold_valid_q, hold_valid_d;
  payload_t [NUM_REQ-1:0] hold_q, hold_d;
  payload_t [NUM_REQ-1:0] req_pl_c;
  logic     [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic                   wb_valid_q, wb_valid_d;
  payload_t               wb_q, wb_d;
  logic     [NUM_REQ-1:0] grant_q, grant_d;

  logic     [NUM_REQ-1:0] gnt_c;
  logic     [PTR_W-1:0]   gnt_idx_c;
  logic                   gnt_any_c;
  logic     [IDX_W-1:0]   scan_idx_c;

  // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ
  always_comb begin
    gnt_c      = '0;
    gnt_idx_c  = '0;
    gnt_any_c  = 1'b0;
    scan_idx_c = '0;
    for (int unsigned n = 0; n < NUM_REQ; n++) begin
      scan_idx_c = IDX_W'(rr_ptr_q) + IDX_W'(n);
      if (scan_idx_c >= IDX_W'(NUM_REQ)) scan_idx_c = scan_idx_c - IDX_W'(NUM_REQ);
      if (!gnt_any_c && hold_valid_q[scan_idx_c[PTR_W-1:0]]) begin
        gnt_any_c = 1'b1;
        gnt_idx_c = scan_idx_c[PTR_W-1:0];
      end
    end
    gnt_c[gnt_idx_c] = gnt_any_c;
  end

  // A hold can take new data when empty or when it is draining this cycle
  assign req_ready_o = ~hold_valid_q | gnt_c;

  always_comb begin
    req_pl_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_pl_c[i].rob_idx      = req_rob_idx_i[i];
      req_pl_c[i].result       = req_result_i[i];
      req_pl_c[i].new_pc       = req_new_pc_i[i];
      req_pl_c[i].branch_taken = req_branch_taken_i[i];
      req_pl_c[i].xcpt         = req_xcpt_i[i];
      req_pl_c[i].xcpt_code    = req_xcpt_code_i[i];
      req_pl_c[i].sb_idx       = req_sb_idx_i[i];
    end
  end

  // Next state: flush drops holds, in-flight transfers and the pending grant
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    rr_ptr_d     = rr_ptr_q;
    wb_valid_d   = 1'b0;
    wb_d         = WB_IDLE;
    grant_d      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (flush_i) begin
        hold_valid_d[i] = 1'b0;
      end else if (req_valid_i[i] && req_ready_o[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_d[i]       = req_pl_c[i];
      end else if (gnt_c[i]) begin
        hold_valid_d[i] = 1'b0;
      end
    end
    if (!flush_i && gnt_any_c) begin
      wb_valid_d = 1'b1;
      wb_d       = hold_q[gnt_idx_c];
      grant_d    = gnt_c;
      rr_ptr_d   = (gnt_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hold_valid_q <= '0;
      hold_q       <= '0;
      rr_ptr_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_q         <= WB_IDLE;
      grant_q      <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      rr_ptr_q     <= rr_ptr_d;
      wb_valid_q   <= wb_valid_d;
      wb_q         <= wb_d;
      grant_q      <= grant_d;
    end
  end

  assign wb_valid_o        = wb_valid_q;
  assign wb_rob_idx_o      = wb_q.rob_idx;
  assign wb_result_o       = wb_q.result;
  assign wb_new_pc_o       = wb_q.new_pc;
  assign wb_branch_taken_o = wb_q.branch_taken;
  assign wb_sb_idx_o       = wb_q.sb_idx;
  assign wb_xcpt_o         = wb_q.xcpt;
  assign wb_xcpt_code_o    = wb_q.xcpt_code;
  assign grant_o           = grant_q;

endmodule
